// File: rtl/div_unit_param_if.sv
// Start/busy/done handshake bundle for the multicycle divider.
// The master issues operands; the slave returns flags and results.
interface div_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, overflow,
    input  quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, overflow,
    output quotient, remainder
  );
endinterface

// File: rtl/div_unit_param.sv
// Parametrised restoring divider, signed/unsigned, one quotient bit per cycle.
// Results and flags hold until the next accepted operation completes.
module div_unit_param #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  div_unit_param_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             ovf_p;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             done_r;
  logic             dbz_r;
  logic             ovf_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             is_min;

  always_comb begin
    a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
    // MIN negates to itself, read back as 2^(WIDTH-1) unsigned
    a_mag   = a_neg ? -bus.dividend : bus.dividend;
    b_mag   = b_neg ? -bus.divisor : bus.divisor;
    is_min  = bus.dividend[WIDTH-1] &
              (bus.dividend[WIDTH-2:0] == '0);
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_mag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs_mag <= '0;
      dvd_raw <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ovf_p   <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= a_mag;
            dvs_mag <= b_mag;
            dvd_raw <= bus.dividend;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            ovf_p   <= bus.is_signed & is_min &
                       (&bus.divisor);
            state   <= (bus.divisor == '0) ?
                       S_ZERO : S_CALC;
          end
        end
        S_CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= S_FIX;
        end
        S_FIX: begin
          q_r    <= neg_q ? -quo : quo;
          r_r    <= neg_r ? -rem[WIDTH-1:0]
                          : rem[WIDTH-1:0];
          ovf_r  <= ovf_p;
          dbz_r  <= 1'b0;
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        S_ZERO: begin
          q_r    <= '1;
          r_r    <= dvd_raw;
          ovf_r  <= 1'b0;
          dbz_r  <= 1'b1;
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
endmodule

// File: tb/tb_div_unit_param.sv
// Directed bench for div_unit_param at WIDTH=32 and WIDTH=8.
// Expected values are hand-computed constants.
module tb_div_unit_param;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  div_unit_param_if #(.WIDTH(32)) bus ();
  div_unit_param_if #(.WIDTH(8))  bus8 ();

  div_unit_param #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  div_unit_param #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic op(
    input  logic        sg,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic        b1
  );
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sg;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1 b1 = bus.busy;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      if (!bus.done) lat++;
    end
    chk("done_seen", bus.done, 1);
  endtask

  int   lat;
  logic b1;
  logic seen;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 0; bus.is_signed = 0;
    bus.dividend = 0; bus.divisor = 0;
    bus8.start = 0; bus8.is_signed = 0;
    bus8.dividend = 0; bus8.divisor = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(negedge clk);
    reset = 1'b0;

    op(1, 32'd7, 32'd2, lat, b1);
    chk("t1_lat", lat, 33);
    chk("t1_busy_e1", b1, 1);
    chk("t1_busy_done", bus.busy, 0);
    chk("t1_q", bus.quotient, 3);
    chk("t1_r", bus.remainder, 1);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_q_hold", bus.quotient, 3);

    op(1, 32'hFFFF_FFF9, 32'd2, lat, b1);
    chk("t2a_q", bus.quotient, 32'hFFFF_FFFD);
    chk("t2a_r", bus.remainder, 32'hFFFF_FFFF);
    op(1, 32'd7, 32'hFFFF_FFFE, lat, b1);
    chk("t2b_lat", lat, 33);
    chk("t2b_q", bus.quotient, 32'hFFFF_FFFD);
    chk("t2b_r", bus.remainder, 1);
    op(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, b1);
    chk("t2c_q", bus.quotient, 3);
    chk("t2c_r", bus.remainder, 32'hFFFF_FFFF);

    op(0, 32'hFFFF_FFFF, 32'd2, lat, b1);
    chk("t3u_q", bus.quotient, 32'h7FFF_FFFF);
    chk("t3u_r", bus.remainder, 1);
    op(1, 32'hFFFF_FFFF, 32'd2, lat, b1);
    chk("t3s_q", bus.quotient, 0);
    chk("t3s_r", bus.remainder, 32'hFFFF_FFFF);

    op(1, 32'h1234, 32'd0, lat, b1);
    chk("t4_lat", lat, 1);
    chk("t4_dbz", bus.div_by_zero, 1);
    chk("t4_q", bus.quotient, 32'hFFFF_FFFF);
    chk("t4_r", bus.remainder, 32'h1234);
    op(0, 32'd100, 32'd7, lat, b1);
    chk("t4n_dbz", bus.div_by_zero, 0);
    chk("t4n_q", bus.quotient, 14);
    chk("t4n_r", bus.remainder, 2);

    op(1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1);
    chk("t5s_q", bus.quotient, 32'h8000_0000);
    chk("t5s_r", bus.remainder, 0);
    chk("t5s_ovf", bus.overflow, 1);
    op(0, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1);
    chk("t5u_q", bus.quotient, 0);
    chk("t5u_r", bus.remainder, 32'h8000_0000);
    chk("t5u_ovf", bus.overflow, 0);

    // second start with new operands lands mid-CALC
    @(negedge clk);
    bus.start = 1; bus.is_signed = 1;
    bus.dividend = 32'd7; bus.divisor = 32'd2;
    @(negedge clk);
    bus.start = 0;
    repeat (5) @(negedge clk);
    bus.start = 1; bus.is_signed = 0;
    bus.dividend = 32'd100; bus.divisor = 32'd3;
    repeat (3) @(negedge clk);
    bus.start = 0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1 seen = bus.done;
      lat++;
    end
    chk("t6_done_seen", seen, 1);
    chk("t6_q", bus.quotient, 3);
    chk("t6_r", bus.remainder, 1);
    @(posedge clk);
    #1 chk("t6_no_restart", bus.busy, 0);

    @(negedge clk);
    bus.start = 1; bus.is_signed = 0;
    bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6r_q", bus.quotient, 0);
    chk("t6r_r", bus.remainder, 0);
    chk("t6r_busy", bus.busy, 0);
    chk("t6r_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 seen = seen | bus.done;
    end
    chk("t6r_no_done", seen, 0);
    op(0, 32'd1000, 32'd10, lat, b1);
    chk("t6r_lat", lat, 33);
    chk("t6r_q2", bus.quotient, 100);
    chk("t6r_r2", bus.remainder, 0);

    @(negedge clk);
    bus8.start = 1; bus8.is_signed = 1;
    bus8.dividend = 8'd100; bus8.divisor = 8'd7;
    @(posedge clk);
    #1 chk("w8_busy_e1", bus8.busy, 1);
    @(negedge clk);
    bus8.start = 0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1 seen = bus8.done;
      lat++;
    end
    chk("w8_lat", lat, 9);
    chk("w8_q", bus8.quotient, 14);
    chk("w8_r", bus8.remainder, 2);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/div_unit_param.md
Name: div_unit_param

Overview:
Parametrised multicycle integer divider, successor to the fixed 32-bit MIPS divider in the execute stage; feeds HI/LO. Supports signed (div) and unsigned (divu) in one datapath, selected per operation. Uses an explicit start/busy/done handshake, defined divide-by-zero results and a signed-overflow flag. Restoring algorithm, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
is_signed  in  1  1 = two's-complement divide, 0 = unsigned; latched with start
dividend  in  WIDTH  numerator; latched with start
divisor  in  WIDTH  denominator; latched with start
busy  out  1  high while an accepted operation is in flight (CALC, FIX)
done  out  1  one-cycle pulse; results valid from this cycle
div_by_zero  out  1  set with done when the latched divisor == 0
overflow  out  1  set with done for signed MIN / -1
quotient  out  WIDTH  result, truncated toward zero
remainder  out  WIDTH  result; sign follows dividend (signed mode)

Behaviour:
- Reset: state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, overflow=0, quotient=0, remainder=0. Reset mid-operation aborts and discards the operation; no done is produced.
- States: IDLE, CALC, FIX, ZERO.
- IDLE and start=1 at edge E0: latch is_signed, raw operands and signs. Compute magnitudes (negate if signed and MSB set; MIN magnitude = 2^(WIDTH-1) unsigned). Clear partial remainder (WIDTH+1 bits) and quotient. counter=0.
  - If divisor==0: go to ZERO.
  - Otherwise: go to CALC.
- CALC, one iteration per edge: shift {rem, quo} left by one, bringing in the next dividend bit. Trial = rem - |divisor|. If trial is non-negative: rem = trial, quotient bit = 1; else quotient bit = 0. counter++. After the WIDTH-th iteration (counter==WIDTH-1 at the edge), go to FIX.
- FIX (1 edge): register the results.
  - quotient = negated magnitude if signed and sign(dividend) != sign(divisor), else magnitude.
  - remainder = negated if signed and dividend was negative, else magnitude.
  - overflow = signed and dividend==MIN and divisor==all-ones. Result is quotient=MIN, remainder=0, which falls out of the datapath naturally.
  - done=1, then go to IDLE.
- ZERO (1 edge): quotient = all ones, remainder = raw dividend, div_by_zero=1, overflow=0, done=1, then go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH+1 (normal case) or E0+1 (divide by zero). busy is high after E0 until the edge that raises done; busy=0 while done=1.
- done is deasserted on the next edge. quotient, remainder, div_by_zero and overflow hold until the FIX/ZERO of the next accepted operation.
- start while busy: ignored; input operand changes during CALC have no effect.
- start high in the same cycle done is high: accepted (state is IDLE); back-to-back throughput is WIDTH+2 cycles.
- Unsigned mode never negates; overflow is always 0.
- Widths: all arithmetic is modulo 2^WIDTH except the (WIDTH+1)-bit trial subtract.

Test Plan:
1. WIDTH=32, signed, 7/2, start at edge 0 -> done high after edge 33; q=3, r=1, busy high edges 1..32.
2. Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 -> q=0xFFFFFFFD, r=1. Signed -7/-2 -> q=3, r=0xFFFFFFFF.
3. Unsigned 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1. Signed with the same operands (-1/2) -> q=0, r=0xFFFFFFFF.
4. Divisor=0, dividend=0x1234 -> done after 1 edge, div_by_zero=1, q=0xFFFFFFFF, r=0x1234. The next normal op clears div_by_zero.
5. Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, overflow=1. The same operands unsigned -> q=0, r=0x80000000, overflow=0.
6. Start pulsed mid-CALC with new operands -> ignored, first result unchanged. Reset at iteration 10 -> outputs 0, no done; a new op completes normally. Repeat test 1 with WIDTH=8 (100/7 -> q=14, r=2, done after edge 9).
